cic_decimator: RTL

- PDM-to-PCM CIC decimator for one MEMS microphone channel; sits directly upstream of the halfband/FIR decimation chain.
- Converts a 1-bit PDM stream, strobed by pdm_en, into 17-bit signed PCM samples at PDM rate / DECIM.
- Output y_out feeds x_in of the downstream halfband/FIR chain.
- Runs entirely on CICCLK; the PDM bit rate is delivered as a clock-enable.

---
 rtl/cic_decimator_pkg.sv | 43 ++++
 rtl/cic_decimator_if.sv | 14 +
 rtl/cic_decimator_comb_stage.sv | 38 +++
 rtl/cic_decimator.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/cic_decimator_pkg.sv
// Shared constants, state encoding and output scaling for the PDM CIC decimator.
package cic_pkg;
    localparam int ORDER      = 4;
    localparam int DECIM      = 32;
    localparam int LOG2_DECIM = $clog2(DECIM);
    localparam int OUT_W      = 17;
    localparam int ACC_W      = 2 + ORDER * LOG2_DECIM;
    localparam int SHIFT      = ACC_W - OUT_W - 1;
    localparam int WARM_W     = $clog2(ORDER + 1);

    localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] SAT_MAX_ACC = ACC_W'(OUT_MAX);
    localparam logic signed [ACC_W-1:0] SAT_MIN_ACC = ACC_W'(OUT_MIN);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2
    } state_t;

    typedef struct packed {
        logic [OUT_W-1:0] y;
        logic             clip;
    } sat_res_t;

    // Arithmetic shift down to output scale, then clamp to the signed output range.
    function automatic sat_res_t scale_sat(input logic signed [ACC_W-1:0] r);
        logic signed [ACC_W-1:0] s;
        sat_res_t res;
        s        = r >>> SHIFT;
        res.y    = OUT_W'(s);
        res.clip = 1'b0;
        if (s > SAT_MAX_ACC) begin
            res.y    = OUT_MAX;
            res.clip = 1'b1;
        end else if (s < SAT_MIN_ACC) begin
            res.y    = OUT_MIN;
            res.clip = 1'b1;
        end
        return res;
    endfunction
endpackage

// File: rtl/cic_decimator_if.sv
// Channel bus between the PDM front end / PCM consumer and the CIC decimator.
// Handshake: pdm_en is a one-cycle strobe qualifying pdm_bit (no backpressure);
// y_valid is a one-cycle strobe qualifying a new y_out, which then holds.
interface cic_decimator_if;
    logic                              en;
    logic                              pdm_en;
    logic                              pdm_bit;
    logic signed [cic_pkg::OUT_W-1:0]  y_out;
    logic                              y_valid;
    logic                              sat;

    modport master (output en, pdm_en, pdm_bit, input  y_out, y_valid, sat);
    modport slave  (input  en, pdm_en, pdm_bit, output y_out, y_valid, sat);
endinterface

// File: rtl/cic_decimator_comb_stage.sv
// One comb section (differential delay 1) with its valid flag carried alongside.
module cic_comb_stage
    import cic_pkg::*;
(
    input  logic                    CICCLK,
    input  logic                    RST,
    input  logic                    i_clear,
    input  logic                    i_valid,
    input  logic signed [ACC_W-1:0] i_data,
    output logic                    o_valid,
    output logic signed [ACC_W-1:0] o_data
);
    logic signed [ACC_W-1:0] r_delay;
    logic signed [ACC_W-1:0] r_data;
    logic                    r_valid;

    // Difference against the previous decimated sample; wraps modulo 2^ACC_W.
    always_ff @(posedge CICCLK or posedge RST) begin
        if (RST) begin
            r_delay <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_clear) begin
            r_delay <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data  <= i_data - r_delay;
                r_delay <= i_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
endmodule

// File: rtl/cic_decimator.sv
// PDM-to-PCM CIC decimator: inline integrator cascade at PDM rate, comb
// pipeline per frame, then shift/saturate into a held PCM output register.
module cic_decimator
    import cic_pkg::*;
(
    input  logic            CICCLK,
    input  logic            RST,
    cic_decimator_if.slave  io_bus,
    output state_t          o_state
);
    state_t                  r_state;
    state_t                  w_next_state;
    logic [LOG2_DECIM-1:0]   r_cnt;
    logic signed [ACC_W-1:0] r_int [ORDER];
    logic                    r_fe;
    logic signed [ACC_W-1:0] r_cap;
    logic                    r_cap_valid;
    logic [WARM_W-1:0]       r_warm;
    logic [OUT_W-1:0]        r_y;
    logic                    r_y_valid;
    logic                    r_sat;

    logic                    w_clear;
    logic                    w_step;
    logic                    w_frame_end;
    logic                    w_out_fire;
    logic                    w_emit;
    logic signed [ACC_W-1:0] w_pdm_val;
    logic signed [ACC_W-1:0] w_comb_data [ORDER+1];
    logic [ORDER:0]          w_comb_valid;
    sat_res_t                w_res;

    assign w_clear     = !io_bus.en;
    assign w_step      = io_bus.en && (r_state != IDLE) && io_bus.pdm_en;
    assign w_frame_end = w_step && (r_cnt == LOG2_DECIM'(DECIM - 1));
    assign w_pdm_val   = io_bus.pdm_bit ? ACC_W'(1) : '1;
    assign w_out_fire  = w_comb_valid[ORDER];
    assign w_res       = scale_sat(w_comb_data[ORDER]);

    // State register.
    always_ff @(posedge CICCLK or posedge RST) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // Next state and emit decision; the (ORDER+1)th frame ends warmup.
    always_comb begin
        w_next_state = r_state;
        w_emit       = 1'b0;
        case (r_state)
            IDLE:    if (io_bus.en) w_next_state = WARMUP;
            WARMUP:  if (w_out_fire && (r_warm == WARM_W'(ORDER))) begin
                         w_next_state = RUN;
                         w_emit       = 1'b1;
                     end
            RUN:     w_emit = w_out_fire;
            default: w_next_state = IDLE;
        endcase
        if (!io_bus.en) begin
            w_next_state = IDLE;
            w_emit       = 1'b0;
        end
    end

    // Integrator cascade and decimation counter, advanced on each PDM strobe.
    always_ff @(posedge CICCLK or posedge RST) begin
        if (RST) begin
            r_cnt <= '0;
            for (int k = 0; k < ORDER; k++) r_int[k] <= '0;
        end else if (w_clear) begin
            r_cnt <= '0;
            for (int k = 0; k < ORDER; k++) r_int[k] <= '0;
        end else if (w_step) begin
            r_cnt    <= r_cnt + 1'b1;
            r_int[0] <= r_int[0] + w_pdm_val;
            for (int k = 1; k < ORDER; k++) r_int[k] <= r_int[k] + r_int[k-1];
        end
    end

    // Capture the last integrator one cycle after the frame-end strobe.
    always_ff @(posedge CICCLK or posedge RST) begin
        if (RST) begin
            r_fe        <= 1'b0;
            r_cap       <= '0;
            r_cap_valid <= 1'b0;
        end else if (w_clear) begin
            r_fe        <= 1'b0;
            r_cap       <= '0;
            r_cap_valid <= 1'b0;
        end else begin
            r_fe        <= w_frame_end;
            r_cap_valid <= r_fe;
            if (r_fe) r_cap <= r_int[ORDER-1];
        end
    end

    assign w_comb_data[0] = r_cap;
    assign w_comb_valid[0] = r_cap_valid;

    genvar g;
    generate
        for (g = 0; g < ORDER; g++) begin : g_comb
            cic_comb_stage u_stage (
                .CICCLK  (CICCLK),
                .RST     (RST),
                .i_clear (w_clear),
                .i_valid (w_comb_valid[g]),
                .i_data  (w_comb_data[g]),
                .o_valid (w_comb_valid[g+1]),
                .o_data  (w_comb_data[g+1])
            );
        end
    endgenerate

    // Output register, sticky saturation flag and warmup frame counter.
    always_ff @(posedge CICCLK or posedge RST) begin
        if (RST) begin
            r_y       <= '0;
            r_y_valid <= 1'b0;
            r_sat     <= 1'b0;
            r_warm    <= '0;
        end else begin
            r_y_valid <= 1'b0;
            if (w_clear) begin
                r_sat  <= 1'b0;
                r_warm <= '0;
            end else if (w_emit) begin
                r_y       <= w_res.y;
                r_y_valid <= 1'b1;
                r_sat     <= r_sat | w_res.clip;
            end else if (w_out_fire && (r_state == WARMUP)) begin
                r_warm <= r_warm + 1'b1;
            end
        end
    end

    assign io_bus.y_out   = r_y;
    assign io_bus.y_valid = r_y_valid;
    assign io_bus.sat     = r_sat;
    assign o_state        = r_state;
endmodule
